// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input handshake and instruction-memory write port of instr_encoder_loader.
// master = producer of bundles / consumer of writes, slave = the loader.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              last;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              busy;
    logic              done;
    logic              full;
    logic              err;
    logic [ADDR_W:0]   count;
    logic [1:0]        dbg_state;

    // Handshake: a bundle is consumed on a rising edge where in_valid && in_ready;
    // in_valid and the fields must be stable while in_valid is high and in_ready is low.
    modport master (
        output start, in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, target, last,
        input  in_ready, im_we, im_addr, im_wdata, busy, done, full, err, count, dbg_state
    );

    modport slave (
        input  start, in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, target, last,
        output in_ready, im_we, im_addr, im_wdata, busy, done, full, err, count, dbg_state
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Assembles R/I/J field bundles into 32-bit MIPS words and writes them sequentially into
// instruction memory. Define ENC_STRICT_EN to reject opcode/field combinations that are not legal.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    instr_encoder_loader_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_FULL} state_e;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP  = '1;

    state_e            state_q;
    logic              im_we_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [31:0]       wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              full_q;
    logic              err_q;
    logic [ADDR_W:0]   count_q;

    logic              in_ready;
    logic              fire;
    logic              reject;
    logic [31:0]       enc_word;
    logic [ADDR_W-1:0] fire_addr;

    assign in_ready = (state_q == S_LOAD) && !bus.start;
    assign fire     = bus.in_valid && in_ready;
    // Every accepted word before this one has been counted, so its address is known at fire time.
    assign fire_addr = BASE + count_q[ADDR_W-1:0];

    always_comb begin
        enc_word = '0;
        reject   = 1'b0;
        case (bus.fmt)
            2'd0: begin
                enc_word = {6'b0, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
`ifdef ENC_STRICT_EN
                reject = (bus.shamt != 5'd0) && !(bus.funct inside {6'h00, 6'h02, 6'h03});
`endif
            end
            2'd1: begin
                enc_word = {bus.opcode, bus.rs, bus.rt, bus.imm};
`ifdef ENC_STRICT_EN
                reject = bus.opcode inside {6'h00, 6'h02, 6'h03};
`endif
            end
            2'd2: begin
                enc_word = {bus.opcode, bus.target};
`ifdef ENC_STRICT_EN
                reject = !(bus.opcode inside {6'h02, 6'h03});
`endif
            end
            default: reject = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            im_we_q <= 1'b0;
            ptr_q   <= BASE;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            im_we_q <= 1'b0;
            if (im_we_q && (ptr_q != TOP)) begin
                ptr_q <= ptr_q + 1'b1;
            end
            if (bus.start) begin
                state_q <= S_LOAD;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                full_q  <= 1'b0;
                err_q   <= 1'b0;
                count_q <= '0;
                ptr_q   <= BASE;
            end else if (fire) begin
                if (reject) begin
                    err_q <= 1'b1;
                    if (bus.last) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end else begin
                    im_we_q <= 1'b1;
                    wdata_q <= enc_word;
                    count_q <= count_q + 1'b1;
                    // Top of memory wins over last; done still reflects last.
                    if (fire_addr == TOP) begin
                        state_q <= S_FULL;
                        busy_q  <= 1'b0;
                        full_q  <= 1'b1;
                        done_q  <= bus.last;
                    end else if (bus.last) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.im_we     = im_we_q;
    assign bus.im_addr   = ptr_q;
    assign bus.im_wdata  = wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.full      = full_q;
    assign bus.err       = err_q;
    assign bus.count     = count_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: three configurations share one stimulus stream and are
// compared every cycle against an address/word reference model.
module tb_instr_encoder_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, in_valid, last;
    logic [1:0]  fmt;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;

    logic [2:0]       obs_ready, obs_we, obs_busy, obs_done, obs_full, obs_err;
    logic [2:0][7:0]  obs_addr;
    logic [2:0][31:0] obs_data;
    logic [2:0][8:0]  obs_cnt;

    int errors = 0;
    int checks = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int AW = (k == 0) ? 8 : (k == 1) ? 2 : 3;
        localparam int BA = (k == 2) ? 5 : 0;
        instr_encoder_loader_if #(.ADDR_W(AW)) bus ();
        assign bus.start    = start;
        assign bus.in_valid = in_valid;
        assign bus.fmt      = fmt;
        assign bus.opcode   = opcode;
        assign bus.rs       = rs;
        assign bus.rt       = rt;
        assign bus.rd       = rd;
        assign bus.shamt    = shamt;
        assign bus.funct    = funct;
        assign bus.imm      = imm;
        assign bus.target   = target;
        assign bus.last     = last;
        instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BA)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign obs_ready[k] = bus.in_ready;
        assign obs_we[k]    = bus.im_we;
        assign obs_busy[k]  = bus.busy;
        assign obs_done[k]  = bus.done;
        assign obs_full[k]  = bus.full;
        assign obs_err[k]   = bus.err;
        assign obs_addr[k]  = 8'(bus.im_addr);
        assign obs_data[k]  = bus.im_wdata;
        assign obs_cnt[k]   = 9'(bus.count);
    end

    function automatic int aw_of(input int k);
        return (k == 0) ? 8 : (k == 1) ? 2 : 3;
    endfunction
    function automatic int base_of(input int k);
        return (k == 2) ? 5 : 0;
    endfunction
    function automatic int top_of(input int k);
        return (1 << aw_of(k)) - 1;
    endfunction

    // Reference model: loader is "accepting" until done/full; next address = base + words written.
    bit          m_load[3], m_err[3], m_done[3], m_full[3], m_we[3];
    int          m_cnt[3], m_waddr[3];
    logic [31:0] m_wdata[3];

    function automatic logic [31:0] ref_word();
        logic [31:0] w;
        case (fmt)
            2'd0:    w = rs * 32'd2097152 + rt * 32'd65536 + rd * 32'd2048 + shamt * 32'd64 + funct;
            2'd1:    w = opcode * 32'd67108864 + rs * 32'd2097152 + rt * 32'd65536 + imm;
            2'd2:    w = opcode * 32'd67108864 + target;
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic bit ref_reject();
        bit r;
        r = (fmt == 2'd3);
`ifdef ENC_STRICT_EN
        if (fmt == 2'd2) r = (opcode != 6'd2) && (opcode != 6'd3);
        if (fmt == 2'd1) r = (opcode == 6'd0) || (opcode == 6'd2) || (opcode == 6'd3);
        if (fmt == 2'd0) r = (shamt != 5'd0) && (funct != 6'h00) && (funct != 6'h02) && (funct != 6'h03);
`endif
        return r;
    endfunction

    task automatic model_step(input int k);
        int a;
        if (!rst_n) begin
            m_load[k] = 0; m_err[k] = 0; m_done[k] = 0; m_full[k] = 0; m_we[k] = 0;
            m_cnt[k] = 0; m_wdata[k] = '0;
        end else begin
            m_we[k] = 0;
            if (start) begin
                m_load[k] = 1; m_err[k] = 0; m_done[k] = 0; m_full[k] = 0; m_cnt[k] = 0;
            end else if (in_valid && m_load[k]) begin
                if (ref_reject()) begin
                    m_err[k] = 1;
                    if (last) begin m_done[k] = 1; m_load[k] = 0; end
                end else begin
                    a = base_of(k) + m_cnt[k];
                    m_we[k] = 1; m_waddr[k] = a; m_wdata[k] = ref_word(); m_cnt[k]++;
                    if (a == top_of(k)) begin m_full[k] = 1; m_load[k] = 0; if (last) m_done[k] = 1; end
                    else if (last) begin m_done[k] = 1; m_load[k] = 0; end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // One clock: check in_ready before the edge, advance model, check registered outputs after.
    task automatic cycle();
        int ea;
        #1;
        for (int k = 0; k < 3; k++) chk("in_ready", k, 32'(obs_ready[k]), 32'(m_load[k] && !start));
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            ea = m_we[k] ? m_waddr[k] : ((base_of(k) + m_cnt[k] > top_of(k)) ? top_of(k) : base_of(k) + m_cnt[k]);
            chk("im_we", k, 32'(obs_we[k]), 32'(m_we[k]));
            chk("im_addr", k, 32'(obs_addr[k]), 32'(ea));
            chk("im_wdata", k, obs_data[k], m_wdata[k]);
            chk("count", k, 32'(obs_cnt[k]), 32'(m_cnt[k]));
            chk("busy", k, 32'(obs_busy[k]), 32'(m_load[k]));
            chk("done", k, 32'(obs_done[k]), 32'(m_done[k]));
            chk("full", k, 32'(obs_full[k]), 32'(m_full[k]));
            chk("err", k, 32'(obs_err[k]), 32'(m_err[k]));
        end
        @(negedge clk);
    endtask

    task automatic set_r(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                         input logic [4:0] sh, input logic [5:0] fn, input logic lst);
        fmt = 2'd0; opcode = 6'h3f; rs = s; rt = t; rd = d; shamt = sh; funct = fn; last = lst;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0; start = 1'b0; last = 1'b0;
    endtask

    task automatic pulse_start();
        idle(); start = 1'b1; cycle(); start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; idle();
        fmt = '0; opcode = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; target = '0;
        for (int k = 0; k < 3; k++) begin m_load[k] = 0; m_cnt[k] = 0; m_wdata[k] = '0; m_we[k] = 0; end
        @(negedge clk);
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();

        // Single R word
        pulse_start();
        set_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 1'b0); cycle(); idle();
        chk("r_word", 0, obs_data[0], 32'h00221820);
        chk("r_we", 0, 32'(obs_we[0]), 32'd1);
        chk("r_addr", 0, 32'(obs_addr[0]), 32'd0);
        chk("r_count", 0, 32'(obs_cnt[0]), 32'd1);
        cycle();

        // I then J(last) back-to-back
        pulse_start();
        fmt = 2'd1; opcode = 6'h08; rs = 5'd0; rt = 5'd8; imm = 16'd5; last = 1'b0; in_valid = 1'b1;
        cycle();
        chk("i_word", 0, obs_data[0], 32'h20080005);
        chk("i_addr", 0, 32'(obs_addr[0]), 32'd0);
        fmt = 2'd2; opcode = 6'h02; target = 26'h0100000; last = 1'b1;
        cycle(); idle();
        chk("j_word", 0, obs_data[0], 32'h08100000);
        chk("j_addr", 0, 32'(obs_addr[0]), 32'd1);
        chk("j_done", 0, 32'(obs_done[0]), 32'd1);
        chk("j_busy", 0, 32'(obs_busy[0]), 32'd0);
        chk("j_ready", 0, 32'(obs_ready[0]), 32'd0);
        cycle();

        // Fill the small memories with a continuous stream of five words
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            set_r(5'($urandom), 5'($urandom), 5'($urandom), 5'd0, 6'h20, 1'b0); cycle();
        end
        idle(); cycle();
        chk("full_aw2", 1, 32'(obs_full[1]), 32'd1);
        chk("cnt_aw2", 1, 32'(obs_cnt[1]), 32'd4);
        chk("full_base5", 2, 32'(obs_full[2]), 32'd1);
        chk("cnt_base5", 2, 32'(obs_cnt[2]), 32'd3);

        // Illegal format between two legal words
        pulse_start();
        set_r(5'd4, 5'd5, 5'd6, 5'd0, 6'h21, 1'b0); cycle();
        fmt = 2'd3; cycle();
        set_r(5'd7, 5'd8, 5'd9, 5'd0, 6'h22, 1'b0); cycle();
        chk("after_bad_addr", 0, 32'(obs_addr[0]), 32'd1);
        idle(); cycle();
        chk("bad_err", 0, 32'(obs_err[0]), 32'd1);
        chk("bad_cnt", 0, 32'(obs_cnt[0]), 32'd2);
`ifdef ENC_STRICT_EN
        pulse_start();
        fmt = 2'd2; opcode = 6'h08; target = 26'h1234; last = 1'b0; in_valid = 1'b1; cycle();
        idle(); cycle();
        chk("strict_j_err", 0, 32'(obs_err[0]), 32'd1);
`endif

        // start right after a fire
        pulse_start();
        set_r(5'd1, 5'd1, 5'd1, 5'd0, 6'h20, 1'b0); cycle();
        pulse_start();
        chk("cancel_we", 0, 32'(obs_we[0]), 32'd0);
        chk("cancel_cnt", 0, 32'(obs_cnt[0]), 32'd0);
        chk("cancel_addr", 2, 32'(obs_addr[2]), 32'd5);

        // Reset mid-stream
        set_r(5'd2, 5'd3, 5'd4, 5'd0, 6'h20, 1'b0); cycle(); cycle();
        rst_n = 1'b0; cycle();
        chk("rst_we", 0, 32'(obs_we[0]), 32'd0);
        chk("rst_data", 0, obs_data[0], 32'd0);
        rst_n = 1'b1; idle(); cycle();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            start    = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            fmt      = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            opcode   = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(2, 3)) : 6'($urandom);
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            shamt    = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
            funct    = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom);
            imm      = 16'($urandom);
            target   = 26'($urandom);
            last     = ($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the pipeline's instruction-format classifier. Takes per-field instruction descriptions (format R/I/J plus fields), assembles 32-bit MIPS words and writes them one at a time into instruction memory.
- Used by the bench/boot path to preload program memory before the pipeline runs.
- Valid/ready input handshake, one-cycle registered write port, sequential address counter, small load FSM.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written after start; must be < 2^ADDR_W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  pulse: clear counters/flags, rewind to BASE_ADDR, enter LOAD.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block accepts bundle this cycle.
- fmt  in  2  0=R, 1=I, 2=J, 3=illegal.
- opcode  in  6  opcode (I/J only; ignored for R).
- rs, rt, rd, shamt  in  5 each  register/shift fields.
- funct  in  6  function field (R).
- imm  in  16  immediate (I).
- target  in  26  jump target (J).
- last  in  1  bundle is final word of program.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  ADDR_W  write word address.
- im_wdata  out  32  encoded instruction.
- busy  out  1  state==LOAD.
- done  out  1  last word written.
- full  out  1  memory top reached.
- err  out  1  sticky: a bundle was rejected.
- count  out  ADDR_W+1  words written since start.

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; in_ready, im_we, busy, done, full, err = 0; im_addr = BASE_ADDR; im_wdata = 0; count = 0. Reset mid-load drops any pending write.
- States: IDLE, LOAD, DONE, FULL. start (any state) -> LOAD; LOAD + accepted word with last=1 -> DONE; LOAD + write to address 2^ADDR_W-1 -> FULL (FULL takes priority if both apply; done also asserted). DONE/FULL hold until start or reset.
- in_ready = (state==LOAD) && !start, combinational. Handshake fires when in_valid && in_ready.
- Encoding: R = {6'b0, rs, rt, rd, shamt, funct}; I = {opcode, rs, rt, imm}; J = {opcode, target}.
- Latency: fire in cycle N -> im_we=1 for exactly cycle N+1 with im_addr = current pointer and im_wdata = encoded word; pointer and count increment in the same cycle N+1. Back-to-back fires give back-to-back writes at consecutive addresses. No wrap: FULL blocks further input.
- Rejected bundle (fmt=3, or strict violation): handshake still completes (consumed), no write, count unchanged, err set sticky. A rejected last=1 bundle still moves the FSM to DONE.
- start same cycle as in_valid: start wins; bundle not accepted. start cancels any write scheduled for the next cycle; err/done/full/count cleared next cycle.
- im_wdata holds last written value when im_we=0.

Optional Feature:
- Macro ENC_STRICT_EN.
- Defined: additional rejection rules, err set. J requires opcode 2 or 3. I rejects opcode 0, 2 and 3. R rejects nonzero shamt when funct is not 0x00, 0x02, 0x03.
- Undefined: only fmt=3 is rejected; opcode/field values are encoded as given.

Test Plan:
- Reset, start, R bundle rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> next cycle im_we=1, im_addr=0, im_wdata=0x00221820, count=1.
- I bundle opcode=0x08 rs=0 rt=8 imm=5, then J bundle opcode=2 target=0x0100000 last=1 back-to-back -> writes 0x20080005 @0 and 0x08100000 @1 on consecutive cycles; done=1, busy=0, in_ready=0.
- ADDR_W=2, BASE_ADDR=0: stream 5 valid R bundles -> 4 writes @0..3, full=1, in_ready=0 after 4th fire, count=4, 5th never accepted.
- fmt=3 bundle between two valid words -> no write for it, err=1, valid words land at addresses 0 and 1. With ENC_STRICT_EN, J with opcode=0x08 also sets err.
- Assert start in the cycle after a fire -> no im_we next cycle, count=0, im_addr=BASE_ADDR. Separately, rst_n=0 mid-stream -> all outputs at reset values next cycle.
